// File: rtl/load_store_unit_pkg.sv
// Shared LSU opcode encodings, access-size codes and opcode decode helpers.
// Combinational helpers only; no latency, no backpressure.
package load_store_unit_pkg;

    localparam int unsigned OP_W = 6;

    // Loads occupy codes up to OP_LHU; stores occupy codes from OP_SB upwards.
    localparam logic [OP_W-1:0] OP_LB  = 6'd1;
    localparam logic [OP_W-1:0] OP_LH  = 6'd2;
    localparam logic [OP_W-1:0] OP_LW  = 6'd3;
    localparam logic [OP_W-1:0] OP_LBU = 6'd4;
    localparam logic [OP_W-1:0] OP_LHU = 6'd5;
    localparam logic [OP_W-1:0] OP_SB  = 6'd6;
    localparam logic [OP_W-1:0] OP_SH  = 6'd7;
    localparam logic [OP_W-1:0] OP_SW  = 6'd8;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic [2:0] op_size(input logic [OP_W-1:0] op);
        logic [2:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// LSB issue, memory-controller and CDB broadcast signals of the LSU.
// Wiring only; slave is the LSU side, master is the surrounding pipeline/memctrl.
interface load_store_unit_if #(
    parameter int ROB_ID_W = 5,
    parameter int XLEN     = 32
);
    logic                en_signal_from_lsb;
    logic [5:0]          inst_name_from_lsb;
    logic [XLEN-1:0]     mem_addr_from_lsb;
    logic [XLEN-1:0]     store_value_from_lsb;
    logic [ROB_ID_W-1:0] rob_id_from_lsb;
    logic                busy_to_lsb;

    logic                en_to_memctrl;
    logic                wr_to_memctrl;
    logic [XLEN-1:0]     addr_to_memctrl;
    logic [2:0]          size_to_memctrl;
    logic [XLEN-1:0]     data_to_memctrl;
    logic                done_from_memctrl;
    logic [XLEN-1:0]     data_from_memctrl;

    logic                valid_to_cdb;
    logic [XLEN-1:0]     result_to_cdb;
    logic [ROB_ID_W-1:0] rob_id_to_cdb;

    modport slave (
        input  en_signal_from_lsb, inst_name_from_lsb, mem_addr_from_lsb,
               store_value_from_lsb, rob_id_from_lsb, done_from_memctrl, data_from_memctrl,
        output busy_to_lsb, en_to_memctrl, wr_to_memctrl, addr_to_memctrl, size_to_memctrl,
               data_to_memctrl, valid_to_cdb, result_to_cdb, rob_id_to_cdb
    );

    modport master (
        output en_signal_from_lsb, inst_name_from_lsb, mem_addr_from_lsb,
               store_value_from_lsb, rob_id_from_lsb, done_from_memctrl, data_from_memctrl,
        input  busy_to_lsb, en_to_memctrl, wr_to_memctrl, addr_to_memctrl, size_to_memctrl,
               data_to_memctrl, valid_to_cdb, result_to_cdb, rob_id_to_cdb
    );
endinterface

// File: rtl/load_store_unit_lsu_load_ext.sv
// Sign/zero extension of right-aligned load data by opcode; purely combinational.
module lsu_load_ext
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_W-1:0] inst_name,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] ext_data
);
    always_comb begin
        ext_data = raw_data;
        case (inst_name)
            OP_LB:   ext_data = {{(XLEN-8){raw_data[7]}}, raw_data[7:0]};
            OP_LH:   ext_data = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
            OP_LBU:  ext_data = {{(XLEN-8){1'b0}}, raw_data[7:0]};
            OP_LHU:  ext_data = {{(XLEN-16){1'b0}}, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// One-deep load/store execution unit: issue -> memctrl request -> CDB pulse one cycle after done.
// Stalls the LSB via busy; `LSU_STAT_EN adds internal load/store/squash/wait-cycle counters.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ROB_ID_W = 5,
    parameter int XLEN     = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   rollback_flag_from_rob,
    load_store_unit_if.slave       bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                en_q, en_d;
    logic                wr_q, wr_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [OP_W-1:0]     inst_q, inst_d;
    logic [ROB_ID_W-1:0] rob_q, rob_d;
    logic                squash_q, squash_d;
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [ROB_ID_W-1:0] rob_cdb_q, rob_cdb_d;
    logic [XLEN-1:0]     ext_data;
    logic                issue_store;
    logic                issue_ok;

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .inst_name (inst_q),
        .raw_data  (bus.data_from_memctrl),
        .ext_data  (ext_data)
    );

    // Stores are already committed by the RoB, so only loads are dropped on rollback.
    assign issue_store = is_store(bus.inst_name_from_lsb);
    assign issue_ok    = bus.en_signal_from_lsb && (issue_store || !rollback_flag_from_rob);

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        inst_d    = inst_q;
        rob_d     = rob_q;
        squash_d  = squash_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rob_cdb_d = rob_cdb_q;
        if (rdy_in) begin
            valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue_ok) begin
                        state_d  = WAIT;
                        en_d     = 1'b1;
                        wr_d     = issue_store;
                        addr_d   = bus.mem_addr_from_lsb;
                        size_d   = op_size(bus.inst_name_from_lsb);
                        data_d   = issue_store ? bus.store_value_from_lsb : '0;
                        inst_d   = bus.inst_name_from_lsb;
                        rob_d    = bus.rob_id_from_lsb;
                        squash_d = 1'b0;
                    end
                end
                default: begin
                    if (rollback_flag_from_rob && !wr_q) squash_d = 1'b1;
                    if (bus.done_from_memctrl) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        if (!wr_q && !squash_q && !rollback_flag_from_rob) begin
                            valid_d   = 1'b1;
                            result_d  = ext_data;
                            rob_cdb_d = rob_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            data_q    <= '0;
            inst_q    <= '0;
            rob_q     <= '0;
            squash_q  <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rob_cdb_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            data_q    <= data_d;
            inst_q    <= inst_d;
            rob_q     <= rob_d;
            squash_q  <= squash_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rob_cdb_q <= rob_cdb_d;
        end
    end

    assign bus.busy_to_lsb     = (state_q != IDLE) || bus.en_signal_from_lsb;
    assign bus.en_to_memctrl   = en_q;
    assign bus.wr_to_memctrl   = wr_q;
    assign bus.addr_to_memctrl = addr_q;
    assign bus.size_to_memctrl = size_q;
    assign bus.data_to_memctrl = data_q;
    assign bus.valid_to_cdb    = valid_q;
    assign bus.result_to_cdb   = result_q;
    assign bus.rob_id_to_cdb   = rob_cdb_q;

    a_no_strobe_when_busy: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && bus.en_signal_from_lsb && state_q != IDLE));

`ifdef LSU_STAT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;
    logic [31:0] wait_cycle_cnt_q, wait_cycle_cnt_d;

    // A squash is counted once: either dropped at issue or first flagged while waiting.
    always_comb begin
        load_cnt_d       = load_cnt_q;
        store_cnt_d      = store_cnt_q;
        squash_cnt_d     = squash_cnt_q;
        wait_cycle_cnt_d = wait_cycle_cnt_q;
        if (rdy_in) begin
            if (state_q == IDLE && issue_ok && !issue_store) load_cnt_d = load_cnt_q + 32'd1;
            if (state_q == IDLE && issue_ok && issue_store)  store_cnt_d = store_cnt_q + 32'd1;
            if ((state_q == IDLE && bus.en_signal_from_lsb && !issue_ok) ||
                (state_q == WAIT && squash_d && !squash_q))
                squash_cnt_d = squash_cnt_q + 32'd1;
            if (state_q == WAIT) wait_cycle_cnt_d = wait_cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            load_cnt_q       <= '0;
            store_cnt_q      <= '0;
            squash_cnt_q     <= '0;
            wait_cycle_cnt_q <= '0;
        end else begin
            load_cnt_q       <= load_cnt_d;
            store_cnt_q      <= store_cnt_d;
            squash_cnt_q     <= squash_cnt_d;
            wait_cycle_cnt_q <= wait_cycle_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic rollback_flag_from_rob;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if #(.ROB_ID_W(5), .XLEN(32)) bus ();

    load_store_unit #(.ROB_ID_W(5), .XLEN(32)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .rollback_flag_from_rob (rollback_flag_from_rob),
        .bus                    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] val, input logic [4:0] rob);
        bus.en_signal_from_lsb   = 1'b1;
        bus.inst_name_from_lsb   = op;
        bus.mem_addr_from_lsb    = addr;
        bus.store_value_from_lsb = val;
        bus.rob_id_from_lsb      = rob;
        #1;
        chk("busy_on_strobe", bus.busy_to_lsb, 1);
        tick();
        bus.en_signal_from_lsb = 1'b0;
        #1;
    endtask

    task automatic finish_mem(input logic [31:0] rdata);
        bus.done_from_memctrl = 1'b1;
        bus.data_from_memctrl = rdata;
        tick();
        bus.done_from_memctrl = 1'b0;
        bus.data_from_memctrl = 32'h0;
        #1;
    endtask

    task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [4:0] rob, input logic [31:0] rdata,
                            input logic [2:0] exp_size, input logic [31:0] exp_res);
        issue(op, addr, 32'h0, rob);
        chk({tag, "_en"}, bus.en_to_memctrl, 1);
        chk({tag, "_wr"}, bus.wr_to_memctrl, 0);
        chk({tag, "_size"}, bus.size_to_memctrl, exp_size);
        chk({tag, "_addr"}, bus.addr_to_memctrl, addr);
        chk({tag, "_busy_wait"}, bus.busy_to_lsb, 1);
        chk({tag, "_novalid_wait"}, bus.valid_to_cdb, 0);
        finish_mem(rdata);
        chk({tag, "_valid"}, bus.valid_to_cdb, 1);
        chk({tag, "_result"}, bus.result_to_cdb, exp_res);
        chk({tag, "_rob"}, bus.rob_id_to_cdb, rob);
        chk({tag, "_en_off"}, bus.en_to_memctrl, 0);
        chk({tag, "_busy_off"}, bus.busy_to_lsb, 0);
        tick();
        chk({tag, "_valid_pulse"}, bus.valid_to_cdb, 0);
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rollback_flag_from_rob   = 1'b0;
        bus.en_signal_from_lsb   = 1'b0;
        bus.inst_name_from_lsb   = 6'd0;
        bus.mem_addr_from_lsb    = 32'h0;
        bus.store_value_from_lsb = 32'h0;
        bus.rob_id_from_lsb      = 5'd0;
        bus.done_from_memctrl    = 1'b0;
        bus.data_from_memctrl    = 32'h0;
        tick();
        tick();
        rst_in = 1'b0;
        #1;
        chk("rst_en", bus.en_to_memctrl, 0);
        chk("rst_wr", bus.wr_to_memctrl, 0);
        chk("rst_valid", bus.valid_to_cdb, 0);
        chk("rst_addr", bus.addr_to_memctrl, 0);
        chk("rst_size", bus.size_to_memctrl, 0);
        chk("rst_data", bus.data_to_memctrl, 0);
        chk("rst_result", bus.result_to_cdb, 0);
        chk("rst_rob", bus.rob_id_to_cdb, 0);
        chk("rst_busy", bus.busy_to_lsb, 0);
        tick();

        run_load("lb",  OP_LB,  32'h100, 5'd3, 32'h0000_00F0, 3'd1, 32'hFFFF_FFF0);
        run_load("lhu", OP_LHU, 32'h104, 5'd4, 32'h0000_8001, 3'd2, 32'h0000_8001);
        run_load("lh",  OP_LH,  32'h108, 5'd5, 32'h0000_8001, 3'd2, 32'hFFFF_8001);
        run_load("lw",  OP_LW,  32'h10C, 5'd6, 32'h1234_5678, 3'd4, 32'h1234_5678);
        run_load("lbu", OP_LBU, 32'h110, 5'd7, 32'hFFFF_FF85, 3'd1, 32'h0000_0085);

        issue(OP_SW, 32'h200, 32'hDEAD_BEEF, 5'd8);
        chk("sw_en", bus.en_to_memctrl, 1);
        chk("sw_wr", bus.wr_to_memctrl, 1);
        chk("sw_size", bus.size_to_memctrl, 4);
        chk("sw_addr", bus.addr_to_memctrl, 32'h200);
        tick();
        tick();
        chk("sw_data_held", bus.data_to_memctrl, 32'hDEAD_BEEF);
        chk("sw_en_held", bus.en_to_memctrl, 1);
        finish_mem(32'h0);
        chk("sw_novalid", bus.valid_to_cdb, 0);
        chk("sw_en_off", bus.en_to_memctrl, 0);
        tick();
        chk("sw_novalid2", bus.valid_to_cdb, 0);

        issue(OP_LW, 32'h300, 32'h0, 5'd9);
        rollback_flag_from_rob = 1'b1;
        tick();
        rollback_flag_from_rob = 1'b0;
        tick();
        tick();
        tick();
        chk("sq_en_held", bus.en_to_memctrl, 1);
        finish_mem(32'h5555_AAAA);
        chk("sq_novalid", bus.valid_to_cdb, 0);
        chk("sq_busy_off", bus.busy_to_lsb, 0);
        issue(OP_SB, 32'h304, 32'h0000_01AB, 5'd10);
        chk("sq_sb_en", bus.en_to_memctrl, 1);
        chk("sq_sb_wr", bus.wr_to_memctrl, 1);
        chk("sq_sb_size", bus.size_to_memctrl, 1);
        chk("sq_sb_data", bus.data_to_memctrl, 32'h0000_01AB);
        finish_mem(32'h0);
        chk("sq_sb_novalid", bus.valid_to_cdb, 0);
        tick();

        rollback_flag_from_rob = 1'b1;
        issue(OP_LB, 32'h400, 32'h0, 5'd11);
        rollback_flag_from_rob = 1'b0;
        #1;
        chk("rbld_no_req", bus.en_to_memctrl, 0);
        chk("rbld_busy", bus.busy_to_lsb, 0);
        tick();
        chk("rbld_novalid", bus.valid_to_cdb, 0);

        rollback_flag_from_rob = 1'b1;
        issue(OP_SH, 32'h404, 32'h0000_BEEF, 5'd12);
        rollback_flag_from_rob = 1'b0;
        #1;
        chk("rbst_req", bus.en_to_memctrl, 1);
        chk("rbst_wr", bus.wr_to_memctrl, 1);
        chk("rbst_size", bus.size_to_memctrl, 2);
        finish_mem(32'h0);
        chk("rbst_novalid", bus.valid_to_cdb, 0);
        tick();

        issue(OP_LW, 32'h500, 32'h0, 5'd13);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_en", bus.en_to_memctrl, 1);
            chk("frz_addr", bus.addr_to_memctrl, 32'h500);
            chk("frz_size", bus.size_to_memctrl, 4);
            chk("frz_novalid", bus.valid_to_cdb, 0);
        end
        rdy_in = 1'b1;
        finish_mem(32'hCAFE_BABE);
        chk("frz_valid", bus.valid_to_cdb, 1);
        chk("frz_result", bus.result_to_cdb, 32'hCAFE_BABE);
        chk("frz_rob", bus.rob_id_to_cdb, 13);
        rdy_in = 1'b0;
        tick();
        chk("frz_valid_hold", bus.valid_to_cdb, 1);
        rdy_in = 1'b1;
        tick();
        chk("frz_valid_clear", bus.valid_to_cdb, 0);

        issue(OP_LH, 32'h600, 32'h0, 5'd14);
        rollback_flag_from_rob = 1'b1;
        finish_mem(32'h0000_7FFF);
        rollback_flag_from_rob = 1'b0;
        #1;
        chk("rbdone_novalid", bus.valid_to_cdb, 0);
        chk("rbdone_idle", bus.busy_to_lsb, 0);

        issue(OP_LB, 32'h700, 32'h0, 5'd15);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
        chk("midrst_en", bus.en_to_memctrl, 0);
        chk("midrst_busy", bus.busy_to_lsb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
